bsg_nor2_rr_arbiter: RTL and testbench
======================================

# bsg_nor2_rr_arbiter

Shares one registered `width_p`-bit bitwise NOR unit among `els_p` requesters. Each requester offers an operand pair under a valid/yumi handshake. A round-robin arbiter picks one requester per cycle. The chosen result, `~(a | b)`, is captured with the requester's index in a single-entry output register, which a downstream consumer drains under valid/yumi. The block sits between several producer lanes and one consumer, so only one NOR datapath is needed.

## Interface
Parameters:
- `width_p`, 16, operand and result width in bits.
- `els_p`, 4, number of requesters; must be at least 1.
- `lg_els_lp`, derived as max(1, clog2(`els_p`)), width of the requester index.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `v_i`  in  `els_p`  per-requester operand-valid.
- `a_i`  in  `els_p*width_p`  operand A; requester k occupies bits [k*width_p +: width_p].
- `b_i`  in  `els_p*width_p`  operand B; same packing as `a_i`.
- `yumi_o`  out  `els_p`  one-hot; requester k's operands are consumed this cycle.
- `v_o`  out  1  output register holds a valid result.
- `data_o`  out  `width_p`  registered result `~(a_k | b_k)`.
- `id_o`  out  `lg_els_lp`  index k of the requester that produced `data_o`.
- `yumi_i`  in  1  consumer accepts `data_o` this cycle; legal only while `v_o`=1.

## Operation
- Internal acceptance condition: `ready` = ~`v_o` | `yumi_i`.
- Grant logic is combinational:
  - When `ready`=1 and any `v_i` bit is set, `yumi_o` is one-hot on the first set `v_i` bit, searching from `last_q`+1 upward and wrapping from `els_p`-1 to 0.
  - When `ready`=0, or no `v_i` bit is set, `yumi_o`=0.
- On a grant to requester k, at the next clock edge:
  - `data_o` <= ~(a_k | b_k), computed bitwise on each bit independently.
  - `id_o` <= k.
  - `v_o` <= 1.
  - `last_q` <= k.
- On `yumi_i`=1 with no grant in the same cycle: `v_o` <= 0. `data_o` and `id_o` hold their values.
- No grant and no `yumi_i`: all state holds.
- `yumi_i` while `v_o`=0 is ignored and must not change state. The bench flags it as a protocol violation.
- Requesters:
  - May assert `v_i` at any time.
  - May deassert `v_i` before being granted. No grant is lost or queued.
  - `a_i`/`b_i` are sampled only in the cycle `yumi_o` is high.
- `yumi_o` never asserts a bit whose `v_i` bit is 0.
- `els_p`=1: the arbiter degenerates to `yumi_o` = `v_i` & `ready`, and `id_o` stays 0.

## Timing
- Reset, asynchronous on `reset_n_i`=0, takes effect immediately:
  - `v_o`=0, `data_o`=0, `id_o`=0.
  - `last_q`=`els_p`-1, so requester 0 has priority first after reset.
  - `yumi_o`=0 while reset is asserted.
- Reset mid-operation discards any held result. A grant in the same cycle as reset assertion is lost; the requester sees it as not taken and re-presents.
- Release of `reset_n_i` is synchronised externally; the block expects deassertion away from `clk_i` edges.
- Latency: a grant in cycle t gives `v_o`=1 with its result in cycle t+1.
- Throughput: one result per cycle when the consumer asserts `yumi_i` every cycle. A simultaneous `yumi_i` and grant replace the entry with no bubble.
- Backpressure:
  - While `v_o`=1 and `yumi_i`=0, `yumi_o`=0.
  - `data_o` and `id_o` stay stable until `yumi_i`.
  - `last_q` does not advance.
- Fairness: with all requesters continuously valid, grants follow the order 0,1,…,`els_p`-1,0,… Any continuously valid requester is granted within `els_p` grants.

## Test plan
- Reset with `width_p`=16, `els_p`=4; check the reset values of all outputs.
  - Then hold `v_i`=4'b0001, a0=16'h00F0, b0=16'h0F00, `yumi_i`=1 → `yumi_o`=0001 in cycle 0; cycle 1: `v_o`=1, `data_o`=16'hF00F, `id_o`=0.
- All four requesters valid, `yumi_i` tied high → `yumi_o` sequence 0001,0010,0100,1000,0001; one result per cycle; `id_o` follows 0,1,2,3 one cycle later.
- Backpressure: `yumi_i`=0 for 5 cycles after the first result → `yumi_o`=0 and `data_o`/`id_o` frozen throughout. Then `yumi_i`=1 → next grant goes to requester 1, with no skip and no repeat.
- Sparse and wrap-around: `last_q`=3, `v_i`=4'b0100 → grant to 2. Next `v_i`=4'b0101 → grant to 0.
  - Requester 1 drops `v_i` before its grant → it is never granted.
- Data sweep: a=16'hFFFF or b=16'hFFFF → 16'h0000; a=b=0 → 16'hFFFF; random pairs are checked bitwise against ~(a|b) across all requesters.
- Reset mid-stream: assert `reset_n_i`=0 between edges while `v_o`=1 → `v_o` drops immediately. After release, the first grant goes to requester 0; `yumi_i` pulsed while `v_o`=0 has no effect.

Source files
------------

// File: rtl/bsg_nor2_rr_arbiter_if.sv
// Requester-side and consumer-side valid/yumi handshakes of the shared NOR arbiter.
// The master modport is the environment's view, the slave modport is the arbiter's view.
interface bsg_nor2_rr_arbiter_if #(
  parameter int width_p = 16,
  parameter int els_p   = 4
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] a_i;
  logic [els_p*width_p-1:0] b_i;
  logic [els_p-1:0]         yumi_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic [lg_els_lp-1:0]     id_o;
  logic                     yumi_i;

  modport master (
    output v_i, a_i, b_i, yumi_i,
    input  yumi_o, v_o, data_o, id_o
  );

  modport slave (
    input  v_i, a_i, b_i, yumi_i,
    output yumi_o, v_o, data_o, id_o
  );
endinterface

// File: rtl/bsg_nor2_rr_arbiter.sv
// Round-robin arbiter sharing one registered bitwise NOR unit among els_p requesters,
// with a single-entry result register drained by the consumer under valid/yumi.
module bsg_nor2_rr_arbiter #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_nor2_rr_arbiter_if.slave   bus
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic                 v_q;
  logic [width_p-1:0]   data_q;
  logic [lg_els_lp-1:0] id_q;
  logic [lg_els_lp-1:0] last_q;

  logic                 ready;
  logic                 found;
  logic                 grant;
  logic [lg_els_lp-1:0] grant_id;
  logic [lg_els_lp-1:0] cand;
  logic [width_p-1:0]   data_d;

  logic [width_p-1:0]   a_arr [els_p];
  logic [width_p-1:0]   b_arr [els_p];

  for (genvar k = 0; k < els_p; k++) begin : g_unpack
    assign a_arr[k] = bus.a_i[k*width_p +: width_p];
    assign b_arr[k] = bus.b_i[k*width_p +: width_p];
  end

  // The entry can take a new result when empty or when it is being drained this cycle.
  assign ready = ~v_q | bus.yumi_i;

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int i = 1; i <= els_p; i++) begin
      cand = lg_els_lp'((int'(last_q) + i) % els_p);
      if (!found && bus.v_i[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign grant      = found & ready & reset_n_i;
  assign bus.yumi_o = grant ? (els_p'(1) << grant_id) : '0;
  assign data_d     = ~(a_arr[grant_id] | b_arr[grant_id]);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= lg_els_lp'(els_p - 1);
    end else if (grant) begin
      v_q    <= 1'b1;
      data_q <= data_d;
      id_q   <= grant_id;
      last_q <= grant_id;
    end else if (bus.yumi_i && v_q) begin
      v_q    <= 1'b0;
    end
  end

  assign bus.v_o    = v_q;
  assign bus.data_o = data_q;
  assign bus.id_o   = id_q;
endmodule

// File: tb/tb_bsg_nor2_rr_arbiter.sv
// Self-checking bench for bsg_nor2_rr_arbiter: a rotating-priority reference model is
// compared against the DUT every cycle, with directed scenarios pinned by literal values.
module tb_bsg_nor2_rr_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetN;
  int   checks   = 0;
  int   failures = 0;
  bit   checkEn  = 1'b0;

  logic [W-1:0] aOp [N];
  logic [W-1:0] bOp [N];

  bsg_nor2_rr_arbiter_if #(.width_p(W), .els_p(N)) io ();

  bsg_nor2_rr_arbiter #(.width_p(W), .els_p(N)) dut (
    .clk_i    (clk),
    .reset_n_i(resetN),
    .bus      (io)
  );

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign io.a_i[k*W +: W] = aOp[k];
    assign io.b_i[k*W +: W] = bOp[k];
  end

  always #5 clk = ~clk;

  // Reference model state: what the output register must hold and who won last.
  bit           mV;
  logic [W-1:0] mData;
  int           mId;
  int           mLast;

  function automatic int pickNext(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((req >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expYumi();
    int g;
    if (resetN !== 1'b1) return '0;
    if (mV && !io.yumi_i) return '0;
    g = pickNext(io.v_i, mLast);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk or negedge resetN) begin
    int g;
    logic [1:0] gi;
    if (!resetN) begin
      mV    = 1'b0;
      mData = '0;
      mId   = 0;
      mLast = N - 1;
    end else begin
      g = (mV && !io.yumi_i) ? -1 : pickNext(io.v_i, mLast);
      if (g >= 0) begin
        gi    = 2'(g);
        mV    = 1'b1;
        mData = ~(aOp[gi] | bOp[gi]);
        mId   = g;
        mLast = g;
      end else if (io.yumi_i && mV) begin
        mV = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the reference model.
  always @(negedge clk) begin
    if (checkEn) begin
      if (resetN === 1'b1 && io.yumi_i && !mV)
        $display("[TB] note: yumi_i asserted while v_o=0 (protocol violation, must be ignored)");
      checkOutput("model yumi_o", 32'(io.yumi_o), 32'(expYumi()));
      checkOutput("model v_o",    32'(io.v_o),    32'(mV));
      checkOutput("model data_o", 32'(io.data_o), 32'(mData));
      checkOutput("model id_o",   32'(io.id_o),   32'(mId));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] v, input bit y);
    @(posedge clk);
    #1;
    io.v_i    = v;
    io.yumi_i = y && mV;
  endtask

  logic [N-1:0] fairSeq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int           fairId  [5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] sweepA  [3] = '{16'hFFFF, 16'h0000, 16'h0000};
  logic [W-1:0] sweepB  [3] = '{16'h0000, 16'hFFFF, 16'h0000};
  logic [W-1:0] sweepR  [3] = '{16'h0000, 16'h0000, 16'hFFFF};

  initial begin
    resetN    = 1'b0;
    io.v_i    = '1;
    io.yumi_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      aOp[k] = '0;
      bOp[k] = '0;
    end
    #2 checkEn = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset yumi_o", 32'(io.yumi_o), 32'h0);
    checkOutput("reset v_o",    32'(io.v_o),    32'h0);
    checkOutput("reset data_o", 32'(io.data_o), 32'h0);
    checkOutput("reset id_o",   32'(io.id_o),   32'h0);
    io.v_i = '0;
    #2 resetN = 1'b1;

    // First transaction after reset goes to requester 0.
    aOp[0] = 16'h00F0;
    bOp[0] = 16'h0F00;
    applyStimulus(4'b0001, 1'b0);
    @(negedge clk);
    checkOutput("first grant yumi_o", 32'(io.yumi_o), 32'h1);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("first v_o",    32'(io.v_o),    32'h1);
    checkOutput("first data_o", 32'(io.data_o), 32'hF00F);
    checkOutput("first id_o",   32'(io.id_o),   32'h0);

    // Fairness with all requesters valid and the consumer always accepting.
    aOp[1] = 16'h1234;
    bOp[1] = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1);
      @(negedge clk);
      checkOutput("fair yumi_o", 32'(io.yumi_o), 32'(fairSeq[i]));
      checkOutput("fair id_o",   32'(io.id_o),   32'(fairId[i]));
    end

    // Backpressure: the held result from requester 1 must stay frozen.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b0);
      @(negedge clk);
      checkOutput("stall yumi_o", 32'(io.yumi_o), 32'h0);
      checkOutput("stall id_o",   32'(io.id_o),   32'h1);
      checkOutput("stall data_o", 32'(io.data_o), 32'hACCA);
    end
    applyStimulus(4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("resume yumi_o", 32'(io.yumi_o), 32'b0100);

    // Sparse requests and wrap-around; requester 1 withdraws before being served.
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("sparse to 3 yumi_o", 32'(io.yumi_o), 32'b1000);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("sparse to 2 yumi_o", 32'(io.yumi_o), 32'b0100);
    applyStimulus(4'b0101, 1'b1);
    @(negedge clk);
    checkOutput("wrap to 0 yumi_o", 32'(io.yumi_o), 32'b0001);
    applyStimulus(4'b1010, 1'b0);
    @(negedge clk);
    checkOutput("withdraw stall yumi_o", 32'(io.yumi_o), 32'h0);
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("withdraw skip yumi_o", 32'(io.yumi_o), 32'b1000);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("withdraw id_o", 32'(io.id_o), 32'h3);

    // Data corner values through requester 0.
    for (int i = 0; i < 3; i++) begin
      aOp[0] = sweepA[i];
      bOp[0] = sweepB[i];
      applyStimulus(4'b0001, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("sweep data_o", 32'(io.data_o), 32'(sweepR[i]));
    end

    // Randomized traffic, checked by the per-cycle model comparison.
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        aOp[k] = W'($urandom);
        bOp[k] = W'($urandom);
      end
      applyStimulus(N'($urandom), ($urandom_range(3) != 0));
    end

    // Reset in the middle of a held result, asserted between clock edges.
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("pre-reset v_o", 32'(io.v_o), 32'h1);
    #2;
    io.v_i = '0;
    resetN = 1'b0;
    #1;
    checkOutput("async reset v_o",    32'(io.v_o),    32'h0);
    checkOutput("async reset yumi_o", 32'(io.yumi_o), 32'h0);
    @(negedge clk);
    #2 resetN = 1'b1;

    @(posedge clk);
    #1;
    io.v_i    = '0;
    io.yumi_i = 1'b1;
    @(negedge clk);
    checkOutput("stray yumi v_o", 32'(io.v_o), 32'h0);
    applyStimulus(4'b1111, 1'b0);
    @(negedge clk);
    checkOutput("post-reset yumi_o", 32'(io.yumi_o), 32'b0001);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("post-reset id_o", 32'(io.id_o), 32'h0);
    checkOutput("post-reset v_o",  32'(io.v_o),  32'h1);

    @(posedge clk);
    #1 checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
